spi_target: RTL
===============

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, sets RX FIFO entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  system clock; all logic SHALL be in this domain.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 ctrl_wr  input  1  bus write request, held until ctrl_done.
REQ-005 ctrl_rd  input  1  bus read request, held until ctrl_done.
REQ-006 ctrl_addr  input  8  register byte address.
REQ-007 ctrl_wdat  input  32  write data.
REQ-008 ctrl_rdat  output  32  read data, valid only in the ctrl_done cycle.
REQ-009 ctrl_done  output  1  one-cycle completion pulse.
REQ-010 spi_sclk  input  1  external master clock, asynchronous.
REQ-011 spi_mosi  input  1  external master data.
REQ-012 spi_cs_n  input  1  external chip select, active-low.
REQ-013 spi_dc  input  1  external data/command flag.
REQ-014 spi_miso  output  1  target data out.
REQ-015 spi_miso_oe  output  1  high while synchronized cs_n is low.

Function
REQ-016 All four SPI inputs SHALL pass 2-flop synchronizers; edges SHALL be detected on the synchronized sclk; supported sclk is at most clk/8.
REQ-017 Leading edge: rising if cpol=0, falling if cpol=1. Sample on the leading edge when cpha=0, on the trailing edge when cpha=1; shift miso on the opposite edge.
REQ-018 Bits SHALL be received MSB first; a 3-bit counter SHALL count samples while cs_n is low.
REQ-019 On the 8th sample, {dc sampled at that edge, byte} (9 bits) SHALL be pushed to the RX FIFO and the counter SHALL wrap to 0.
REQ-020 Push while FIFO is full: entry dropped, FIFO unchanged, sticky overflow set.
REQ-021 cs_n rising mid-byte: partial bits discarded, counter cleared, no push.
REQ-022 Byte start (cs_n falling, or counter wrap while cs_n low): the TX shadow SHALL load tx_data and clear tx_pending if pending, else load 0xFF.
REQ-023 cpha=0: shadow MSB on spi_miso in the cycle after the load; cpha=1: MSB driven at the first leading edge; subsequent bits shift on each shift edge.
REQ-024 Register 0x00 (read): [0] rx_empty, [1] rx_full, [2] overflow, [3] tx_pending, [8:4] rx_count; other bits 0.
REQ-025 Register 0x04 (read): {23'b0, dc, byte} of FIFO head, then pop; empty FIFO returns 0x00000000, no pop.
REQ-026 Register 0x08: write loads tx_data[7:0] and sets tx_pending; read returns tx_data.
REQ-027 Register 0x0C: bit1 cpol, bit0 cpha, read/write; a write takes effect at the next cs_n falling edge.
REQ-028 Register 0x10 (write): bit0=1 clears overflow, bit1=1 flushes the FIFO; reads return 0.
REQ-029 ctrl_done SHALL pulse exactly one cycle after a request is seen while ctrl_done is low; other addresses complete with rdat 0, no effect.
REQ-030 FIFO push and pop in the same cycle: both happen and rx_count is unchanged; push into a full FIFO with simultaneous pop SHALL succeed.
REQ-031 Flush coincident with a push: the flush wins and the FIFO ends empty.

Reset
REQ-032 resetn low: FIFO empty, overflow 0, tx_data 0x00, tx_pending 0, cpol=1, cpha=1, counter 0, synchronizers at idle (cs_n 1), spi_miso 1, spi_miso_oe 0, ctrl_done 0.
REQ-033 Reset asserted mid-transfer SHALL abort the byte, and the next byte is received only after a fresh cs_n falling edge.

Structure
REQ-034 Register offsets, status bit positions and reset mode values SHALL live in shared package spi_target_pkg.
REQ-035 The RX FIFO SHALL be sub-module spi_target_fifo (9-bit width, FIFO_DEPTH, push/pop/flush, count).

Verification
REQ-036 Mode 3: master sends 0xA5 with dc=1 -> status rx_count=1; read 0x04 returns 0x1A5; status then rx_empty=1.
REQ-037 Mode 0: write 0x08=0x3C, master clocks one byte -> miso carries 0x3C MSB first; tx_pending=0; the next byte carries 0xFF.
REQ-038 9 bytes into an 8-deep FIFO -> rx_full=1, overflow=1, first 8 bytes read back in order; write 0x10=1 clears overflow.
REQ-039 cs_n deasserted after 5 bits, then a full 0x81 sent -> exactly one entry, 0x081 with dc=0.
REQ-040 Pop and push in the same cycle with rx_count=8 -> count stays 8, no overflow.
REQ-041 resetn pulsed after 4 bits of a byte -> FIFO empty and mode reads 0x3; the following full byte is received correctly.

Source files
------------

// File: rtl/spi_target_pkg.sv
// spi_target_pkg: register map, status bit positions and reset mode shared by the SPI target.
package spi_target_pkg;
   localparam logic [7:0] A_STATUS = 8'h00;
   localparam logic [7:0] A_RXDATA = 8'h04;
   localparam logic [7:0] A_TXDATA = 8'h08;
   localparam logic [7:0] A_MODE   = 8'h0C;
   localparam logic [7:0] A_CTRL   = 8'h10;
   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_OVF   = 2;
   localparam int ST_TXP   = 3;
   localparam int ST_CNT   = 4;
   typedef struct packed {
      logic cpol;
      logic cpha;
   } mode_t;
   localparam mode_t RST_MODE = '{cpol: 1'b1, cpha: 1'b1};
endpackage

// File: rtl/spi_target_fifo.sv
// spi_target_fifo: synchronous FIFO for received SPI entries with flush and fill count.
module spi_target_fifo #(
   parameter int DEPTH = 8,
   parameter int W = 9
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [W-1:0]           wdat,
   output logic [W-1:0]           rdat,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign empty = count == '0;
   assign full = count == FULL_CNT;
   assign do_pop = pop & ~empty;
   // a pop frees the slot the same cycle, so a full FIFO still accepts the push
   assign do_push = push & (~full | do_pop);
   assign rdat = mem[rp];
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= wdat;
   end
   always_ff @(posedge clk) begin
      if (!resetn || flush) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/spi_target.sv
// spi_target: SPI target with synchronized pin sampling, a 9-bit RX FIFO,
// a TX shadow register and a request/done register bus.
module spi_target
   import spi_target_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ctrl_wr,
   input  logic        ctrl_rd,
   input  logic [7:0]  ctrl_addr,
   input  logic [31:0] ctrl_wdat,
   output logic [31:0] ctrl_rdat,
   output logic        ctrl_done,
   input  logic        spi_sclk,
   input  logic        spi_mosi,
   input  logic        spi_cs_n,
   input  logic        spi_dc,
   output logic        spi_miso,
   output logic        spi_miso_oe
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic [2:0] sclk_p, cs_p;
   logic [1:0] mosi_p, dc_p, settle;
   logic armed;
   mode_t mode_q, act, m;
   logic cs_low, cs_fall, rise, fall, lead, trail, smp, shf, wrap, load;
   logic [2:0] bit_cnt;
   logic [6:0] rx_sh;
   logic [7:0] tx_sh, tx_data, tx_val;
   logic tx_pending, overflow;
   logic req, wr, rd, pop, flush, ovf_set, empty, full, unused_wdat;
   logic [8:0] head;
   logic [CW-1:0] rx_count;
   logic [31:0] status, rdat_nxt;

   // cs_n held low across reset must not resume a byte: wait to see it high first
   assign cs_low = ~cs_p[1] & armed;
   assign cs_fall = cs_low & cs_p[2];
   assign m = cs_fall ? mode_q : act;
   assign rise = sclk_p[1] & ~sclk_p[2];
   assign fall = ~sclk_p[1] & sclk_p[2];
   assign lead = m.cpol ? fall : rise;
   assign trail = m.cpol ? rise : fall;
   assign smp = cs_low & (m.cpha ? trail : lead);
   // with cpha=0 the trailing edge after the last sample belongs to the next byte's MSB
   assign shf = cs_low & (m.cpha ? lead : trail) & (m.cpha | (bit_cnt != 3'd0));
   assign wrap = smp & (bit_cnt == 3'd7);
   assign load = cs_fall | wrap;
   assign tx_val = tx_pending ? tx_data : 8'hFF;
   assign spi_miso_oe = ~cs_p[1];

   assign req = (ctrl_wr | ctrl_rd) & ~ctrl_done;
   assign wr = req & ctrl_wr;
   assign rd = req & ctrl_rd;
   assign pop = rd & (ctrl_addr == A_RXDATA) & ~empty;
   assign flush = wr & (ctrl_addr == A_CTRL) & ctrl_wdat[1];
   assign ovf_set = wrap & full & ~pop & ~flush;
   assign unused_wdat = ^ctrl_wdat[31:8];

   spi_target_fifo #(.DEPTH(FIFO_DEPTH), .W(9)) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (wrap),
      .pop    (pop),
      .flush  (flush),
      .wdat   ({dc_p[1], rx_sh, mosi_p[1]}),
      .rdat   (head),
      .empty  (empty),
      .full   (full),
      .count  (rx_count)
   );

   always_comb begin
      status = '0;
      status[ST_EMPTY] = empty;
      status[ST_FULL] = full;
      status[ST_OVF] = overflow;
      status[ST_TXP] = tx_pending;
      status[ST_CNT +: 5] = 5'(rx_count);
      rdat_nxt = '0;
      if (rd)
         rdat_nxt = ctrl_addr == A_STATUS ? status :
                    ctrl_addr == A_RXDATA ? {23'b0, empty ? 9'h0 : head} :
                    ctrl_addr == A_TXDATA ? {24'b0, tx_data} :
                    ctrl_addr == A_MODE   ? {30'b0, mode_q} : '0;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sclk_p <= {3{RST_MODE.cpol}};
         cs_p <= 3'b111;
         mosi_p <= '0;
         dc_p <= '0;
         settle <= '0;
         armed <= 1'b0;
         act <= RST_MODE;
         bit_cnt <= '0;
         rx_sh <= '0;
         tx_sh <= 8'hFF;
         spi_miso <= 1'b1;
      end else begin
         sclk_p <= {sclk_p[1:0], spi_sclk};
         cs_p <= {cs_p[1:0], spi_cs_n};
         mosi_p <= {mosi_p[0], spi_mosi};
         dc_p <= {dc_p[0], spi_dc};
         settle <= {settle[0], 1'b1};
         armed <= armed | (settle[1] & cs_p[1]);
         if (cs_fall) act <= mode_q;
         if (!cs_low) bit_cnt <= '0;
         else if (smp) begin
            bit_cnt <= bit_cnt + 3'd1;
            rx_sh <= {rx_sh[5:0], mosi_p[1]};
         end
         if (load) begin
            tx_sh <= m.cpha ? tx_val : {tx_val[6:0], 1'b1};
            if (!m.cpha) spi_miso <= tx_val[7];
         end else if (shf) begin
            spi_miso <= tx_sh[7];
            tx_sh <= {tx_sh[6:0], 1'b1};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ctrl_done <= 1'b0;
         ctrl_rdat <= '0;
         tx_data <= '0;
         tx_pending <= 1'b0;
         mode_q <= RST_MODE;
         overflow <= 1'b0;
      end else begin
         ctrl_done <= req;
         ctrl_rdat <= rdat_nxt;
         if (load) tx_pending <= 1'b0;
         if (wr && ctrl_addr == A_TXDATA) begin
            tx_data <= ctrl_wdat[7:0];
            tx_pending <= 1'b1;
         end
         if (wr && ctrl_addr == A_MODE) mode_q <= mode_t'(ctrl_wdat[1:0]);
         if (ovf_set) overflow <= 1'b1;
         if (wr && ctrl_addr == A_CTRL && ctrl_wdat[0]) overflow <= 1'b0;
      end
   end
endmodule
